// File: rtl/sr194_load_shift_ctrl.sv
// Sequencer for a '194 universal shift register: parallel-loads a handshaken word, then right-shifts it out of QD (D first).
// Accept -> first SER_VALID in 2 cycles, -> DONE pulse in SHIFTS+2; IN_READY is low while busy or while ABORT is high.
module sr194_load_shift_ctrl #(
  parameter int SHIFTS = 4,
  parameter int CW     = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_DATA,
  input  logic       FILL,
  input  logic       ABORT,
  output logic       S1,
  output logic       S0,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       RIN,
  output logic       LIN,
  input  logic       QD,
  output logic       SER_OUT,
  output logic       SER_VALID,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFTS - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic [3:0]    r_word;
  logic          r_fill;
  logic          w_accept;

  assign w_accept = (r_state == ST_IDLE) & IN_VALID & ~ABORT;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_word <= IN_DATA;
        r_fill <= FILL;
      end
    end
  end

  // Mode selects and status are decoded from state only; SER_OUT is the sole input-to-output path besides IN_READY.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    IN_READY     = 1'b0;
    S1           = 1'b0;
    S0           = 1'b0;
    RIN          = 1'b0;
    SER_OUT      = 1'b0;
    SER_VALID    = 1'b0;
    BUSY         = 1'b1;
    DONE         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        BUSY     = 1'b0;
        IN_READY = ~ABORT;
        if (w_accept) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        S1         = 1'b1;
        S0         = 1'b1;
        w_next_cnt = '0;
        w_next_state = ABORT ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        S0        = 1'b1;
        RIN       = r_fill;
        SER_VALID = 1'b1;
        SER_OUT   = QD;
        if (ABORT) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_next_state = ST_DONE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        DONE         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign A   = r_word[3];
  assign B   = r_word[2];
  assign C   = r_word[1];
  assign D   = r_word[0];
  assign LIN = 1'b0;

endmodule

// File: tb/tb_sr194_load_shift_ctrl.sv
// Bench: two controllers (SHIFTS=4 and 6) each driving a behavioural '194 register, checked against a word-level model.
module tb_sr194_load_shift_ctrl;

  typedef struct packed {
    logic in_ready, s1, s0, a, b, c, d, rin, lin, ser_out, ser_vld, busy, done;
  } obs_t;

  typedef struct {
    logic       valid;
    logic [3:0] data;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, in_valid, fill, abort;
  logic [3:0] in_data;

  obs_t       obs  [2];
  logic [3:0] regq [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SH = (g == 0) ? 4 : 6;
    logic in_ready, s1, s0, a, b, c, d, rin, lin, ser_out, ser_vld, busy, done;
    logic [3:0] q;

    sr194_load_shift_ctrl #(.SHIFTS(SH), .CW(4)) u_dut (
      .CLK(clk), .CLR(clr), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
      .FILL(fill), .ABORT(abort), .S1(s1), .S0(s0), .A(a), .B(b), .C(c), .D(d),
      .RIN(rin), .LIN(lin), .QD(q[0]), .SER_OUT(ser_out), .SER_VALID(ser_vld),
      .BUSY(busy), .DONE(done)
    );

    // q = {QA,QB,QC,QD}; CLR_L of the register is the inverse of CLR
    always_ff @(posedge clk or posedge clr) begin
      if (clr) q <= 4'b0000;
      else begin
        case ({s1, s0})
          2'b11:   q <= {a, b, c, d};
          2'b01:   q <= {rin, q[3:1]};
          2'b10:   q <= {q[2:0], lin};
          default: q <= q;
        endcase
      end
    end

    assign obs[g]  = {in_ready, s1, s0, a, b, c, d, rin, lin, ser_out, ser_vld, busy, done};
    assign regq[g] = q;
  end

  int checks = 0;
  int errors = 0;

  // Word-level model: pos = cycles since the accept edge (-1 when no word is in flight)
  int         pos [2];
  logic [3:0] mw  [2];
  logic       mf  [2];

  int          done_cnt [2];
  int          ser_n    [2];
  logic [31:0] ser_log  [2];
  int          idle0;

  vec_t tab [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sh_of(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  function automatic obs_t mk(input logic rdy, input logic [1:0] s, input logic [3:0] w,
                              input logic so, input logic sv, input logic bsy, input logic dn);
    obs_t o;
    o = '0;
    o.in_ready = rdy;
    o.s1 = s[1];
    o.s0 = s[0];
    {o.a, o.b, o.c, o.d} = w;
    o.ser_out = so;
    o.ser_vld = sv;
    o.busy = bsy;
    o.done = dn;
    return o;
  endfunction

  function automatic obs_t model_exp(input int i);
    obs_t e;
    int   sh;
    int   k;
    sh = sh_of(i);
    e  = '0;
    if (clr) begin
      e.in_ready = !abort;
      return e;
    end
    {e.a, e.b, e.c, e.d} = mw[i];
    if (pos[i] < 0) begin
      e.in_ready = !abort;
    end else if (pos[i] == 0) begin
      e.s1 = 1'b1;
      e.s0 = 1'b1;
      e.busy = 1'b1;
    end else if (pos[i] <= sh) begin
      k = pos[i] - 1;
      e.s0 = 1'b1;
      e.busy = 1'b1;
      e.rin = mf[i];
      e.ser_vld = 1'b1;
      e.ser_out = (k < 4) ? mw[i][k] : mf[i];
    end else begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic model_step(input int i);
    int sh;
    sh = sh_of(i);
    if (clr) begin
      pos[i] = -1;
      mw[i]  = 4'b0000;
      mf[i]  = 1'b0;
    end else if (pos[i] < 0) begin
      if (in_valid && !abort) begin
        pos[i] = 0;
        mw[i]  = in_data;
        mf[i]  = fill;
      end
    end else if (pos[i] <= sh && abort) begin
      pos[i] = -1;
    end else if (pos[i] == sh + 1) begin
      pos[i] = -1;
    end else begin
      pos[i]++;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      ser_n[i]    = 0;
      ser_log[i]  = '0;
    end
    idle0 = 0;
  endtask

  // One clock cycle: inputs are already driven; compare mid-cycle, then advance the model at the edge.
  task automatic tick(input bit use_tab, input obs_t tab_exp);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_inst%0d", i), 32'(obs[i]), 32'(model_exp(i)));
      if (obs[i].done) done_cnt[i]++;
      if (obs[i].ser_vld) begin
        if (ser_n[i] < 32) ser_log[i][ser_n[i][4:0]] = obs[i].ser_out;
        ser_n[i]++;
      end
    end
    if (!obs[0].busy) idle0++;
    if (use_tab) check("table_vec", 32'(obs[0]), 32'(tab_exp));
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
  endtask

  task automatic step();
    tick(1'b0, '0);
  endtask

  initial begin
    tab[0] = '{1'b1, 4'hB, mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tab[1] = '{1'b0, 4'hB, mk(1'b0, 2'b11, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0)};
    tab[2] = '{1'b0, 4'hB, mk(1'b0, 2'b01, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0)};
    tab[3] = '{1'b0, 4'hB, mk(1'b0, 2'b01, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0)};
    tab[4] = '{1'b0, 4'hB, mk(1'b0, 2'b01, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0)};
    tab[5] = '{1'b0, 4'hB, mk(1'b0, 2'b01, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0)};
    tab[6] = '{1'b0, 4'hB, mk(1'b0, 2'b00, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1)};
    tab[7] = '{1'b0, 4'hB, mk(1'b1, 2'b00, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0)};

    for (int i = 0; i < 2; i++) begin
      pos[i] = -1;
      mw[i]  = 4'b0000;
      mf[i]  = 1'b0;
    end
    clear_logs();
    clr = 1'b1; in_valid = 1'b0; in_data = 4'h0; fill = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs[0]), 32'(mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)));
    check("reset_reg", 32'(regq[0]), 32'(4'b0000));
    clr = 1'b0;

    // Single word 1011, FILL=0, SHIFTS=4
    for (int r = 0; r < 8; r++) begin
      in_valid = tab[r].valid;
      in_data  = tab[r].data;
      tick(1'b1, tab[r].exp);
    end
    check("single_reg_end", 32'(regq[0]), 32'(4'b0000));
    check("single_ser_count", 32'(ser_n[0]), 32'd4);
    check("single_ser_bits", 32'(ser_log[0][3:0]), 32'(4'b1011));
    check("single_done_count", 32'(done_cnt[0]), 32'd1);
    repeat (4) step();

    // Fill overrun on the SHIFTS=6 instance
    clear_logs();
    in_valid = 1'b1; in_data = 4'b0110; fill = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("fill_ser_count", 32'(ser_n[1]), 32'd6);
    check("fill_ser_bits", 32'(ser_log[1][5:0]), 32'(6'b110110));
    check("fill_reg_end", 32'(regq[1]), 32'(4'b1111));
    check("fill_done_count", 32'(done_cnt[1]), 32'd1);

    // Back-to-back words A then 5 with IN_VALID held high
    clear_logs();
    fill = 1'b0;
    in_valid = 1'b1; in_data = 4'hA;
    step();
    idle0 = 0;
    in_data = 4'h5;
    repeat (7) step();
    in_valid = 1'b0;
    repeat (6) step();
    check("b2b_idle_gap", 32'(idle0), 32'd1);
    check("b2b_ser_count", 32'(ser_n[0]), 32'd8);
    check("b2b_ser_bits", 32'(ser_log[0][7:0]), 32'(8'h5A));
    check("b2b_done_count", 32'(done_cnt[0]), 32'd2);
    repeat (3) step();

    // ABORT during SHIFT cycle k=1
    clear_logs();
    in_valid = 1'b1; in_data = 4'h6;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b1; in_data = 4'h9;
    #1;
    check("abort_idle_busy", 32'(obs[0].busy), 32'd0);
    check("abort_idle_mode", 32'({obs[0].s1, obs[0].s0}), 32'd0);
    check("abort_idle_ready", 32'(obs[0].in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check("abort_reaccept_mode", 32'({obs[0].s1, obs[0].s0}), 32'(2'b11));
    check("abort_reaccept_word", 32'({obs[0].a, obs[0].b, obs[0].c, obs[0].d}), 32'(4'h9));
    check("abort_no_done", 32'(done_cnt[0]), 32'd0);
    repeat (9) step();

    // ABORT in IDLE blocks the accept
    clear_logs();
    abort = 1'b1; in_valid = 1'b1; in_data = 4'h3;
    #1;
    check("idle_abort_ready", 32'(obs[0].in_ready), 32'd0);
    repeat (2) step();
    check("idle_abort_no_accept", 32'(obs[0].busy), 32'd0);
    abort = 1'b0;
    #1;
    check("idle_abort_ready_back", 32'(obs[0].in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check("idle_abort_accept", 32'({obs[0].s1, obs[0].s0}), 32'(2'b11));
    repeat (9) step();

    // CLR mid-SHIFT
    clear_logs();
    in_valid = 1'b1; in_data = 4'b1011;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    #1;
    check("clr_outputs", 32'(obs[0]), 32'(mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)));
    check("clr_reg", 32'(regq[0]), 32'(4'b0000));
    check("clr_outputs_inst1", 32'(obs[1]), 32'(mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)));
    repeat (2) step();
    clr = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    step();
    in_valid = 1'b0;
    #1;
    check("clr_first_edge_accept", 32'({obs[0].s1, obs[0].s0}), 32'(2'b11));
    repeat (9) step();
    check("clr_done_count", 32'(done_cnt[0]), 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      clr      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom_range(0, 15));
      fill     = 1'($urandom_range(0, 1));
      abort    = ($urandom_range(0, 9) == 0);
      step();
    end
    clr = 1'b0; in_valid = 1'b0; abort = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
